// File: rtl/dcache_ctrl_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// FSM encoding, default geometry and byte-lane merge.
package dcache_ctrl_pkg;

  localparam int unsigned INDEX_BITS_DEF = 6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_DONE = 3'd4
  } state_e;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  mask
  );
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Flop-based valid/tag/data storage with a combinational read port.
// Valid bits clear on reset; tag and data arrays are never reset.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_BITS-1:0] idx_i,
  input  logic [29-INDEX_BITS:0] tag_i,
  input  logic                  fill_i,
  input  logic                  upd_i,
  input  logic [3:0]            wmask_i,
  input  logic [31:0]           wdata_i,
  output logic                  hit_o,
  output logic [31:0]           rdata_o
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && fill_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= wdata_i;
    end else if (!rst_i && upd_i) begin
      data_q[idx_i] <= merge_bytes(data_q[idx_i], wdata_i, wmask_i);
    end
  end

  assign hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
  assign rdata_o = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache controller: hit/miss FSM, memory handshake and load counters.
// Write-through, no-write-allocate; hits return data in the same cycle.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_re,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  state_e      state_q, state_d;
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        hit, fill, upd, hit_inc, miss_inc, is_store;
  logic [31:0] rdata;
  logic        addr_unused;

  assign addr_unused = ^cpu_addr[1:0];
  assign is_store    = |cpu_we;

  dcache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk_i   (clk),
    .rst_i   (reset),
    .idx_i   (cpu_addr[INDEX_BITS+1:2]),
    .tag_i   (cpu_addr[31:INDEX_BITS+2]),
    .fill_i  (fill),
    .upd_i   (upd),
    .wmask_i (cpu_we),
    .wdata_i (fill ? mem_resp_data : cpu_din),
    .hit_o   (hit),
    .rdata_o (rdata)
  );

  assign mem_req_addr = cpu_addr[31:2];
  assign mem_req_data = cpu_din;
  assign mem_req_mask = cpu_we;

  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    cpu_dout      = '0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    fill          = 1'b0;
    upd           = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    if (reset) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (is_store) begin
            stall   = 1'b1;
            state_d = S_WR_REQ;
          end else if (cpu_re && hit) begin
            cpu_dout = rdata;
            hit_inc  = 1'b1;
          end else if (cpu_re) begin
            stall    = 1'b1;
            miss_inc = 1'b1;
            state_d  = S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          stall         = 1'b1;
          mem_req_valid = 1'b1;
          if (mem_req_ready) state_d = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          stall = 1'b1;
          if (mem_resp_valid) begin
            fill    = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_WR_REQ: begin
          stall         = 1'b1;
          mem_req_valid = 1'b1;
          mem_req_rw    = 1'b1;
          if (mem_req_ready) begin
            upd     = hit;
            state_d = S_WR_DONE;
          end
        end
        // Held store is ignored here so it is not issued twice.
        S_WR_DONE: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_q + {31'd0, hit_inc};
      miss_cnt_q <= miss_cnt_q + {31'd0, miss_inc};
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed and randomized bench for dcache_ctrl against a line/memory model.
// Acts as both CPU and backing memory.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  dcache_ctrl #(.INDEX_BITS(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_addr       (cpu_addr),
    .cpu_re         (cpu_re),
    .cpu_we         (cpu_we),
    .cpu_din        (cpu_din),
    .cpu_dout       (cpu_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_mask   (mem_req_mask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int nreq = 0;

  always @(posedge clk) if (mem_req_valid && mem_req_ready) nreq++;

  bit          mv [64];
  logic [23:0] mt [64];
  logic [31:0] md [64];
  logic [31:0] mem [bit [29:0]];
  logic [31:0] mh, mm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rd_mem(input logic [29:0] w);
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    mh = 0;
    mm = 0;
  endtask

  task automatic chk_counts;
    chk("hit_count", hit_count, mh);
    chk("miss_count", miss_count, mm);
  endtask

  task automatic do_load(input logic [31:0] a, input int rq, input int rs,
                         output logic [31:0] got);
    int n0;
    int miss;
    logic [5:0]  idx;
    logic [29:0] w;
    n0 = nreq;
    idx = a[7:2];
    w = a[31:2];
    cpu_addr = a;
    cpu_re = 1'b1;
    cpu_we = 4'b0;
    cpu_din = $urandom;
    #1;
    miss = !(mv[idx] && mt[idx] == a[31:8]);
    if (miss) begin
      chk("ld_miss_stall", stall, 1);
      mm++;
      tick;
      for (int i = 0; i <= rq; i++) begin
        mem_req_ready = (i == rq);
        #1;
        chk("rd_reqv", mem_req_valid, 1);
        chk("rd_rw", mem_req_rw, 0);
        chk("rd_addr", mem_req_addr, w);
        chk("rd_stall", stall, 1);
        tick;
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i <= rs; i++) begin
        mem_resp_valid = (i == rs);
        if (i == rs) mem_resp_data = rd_mem(w);
        else mem_resp_data = $urandom;
        #1;
        chk("rdw_stall", stall, 1);
        chk("rdw_reqv", mem_req_valid, 0);
        tick;
      end
      mem_resp_valid = 1'b0;
      mv[idx] = 1'b1;
      mt[idx] = a[31:8];
      md[idx] = mem[w];
      #1;
    end
    chk("ld_stall", stall, 0);
    chk("ld_dout", cpu_dout, md[idx]);
    chk("ld_reqv", mem_req_valid, 0);
    got = cpu_dout;
    tick;
    mh++;
    cpu_re = 1'b0;
    chk("ld_nreq", nreq - n0, miss);
    chk_counts();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] mask,
                          input logic [31:0] din, input int rq);
    int n0;
    logic [5:0]  idx;
    logic [29:0] w;
    logic [31:0] old;
    n0 = nreq;
    idx = a[7:2];
    w = a[31:2];
    cpu_addr = a;
    cpu_we = mask;
    cpu_din = din;
    cpu_re = 1'($urandom);
    #1;
    chk("st_stall", stall, 1);
    tick;
    for (int i = 0; i <= rq; i++) begin
      mem_req_ready = (i == rq);
      #1;
      chk("wr_reqv", mem_req_valid, 1);
      chk("wr_rw", mem_req_rw, 1);
      chk("wr_addr", mem_req_addr, w);
      chk("wr_data", mem_req_data, din);
      chk("wr_mask", mem_req_mask, mask);
      chk("wr_stall", stall, 1);
      tick;
    end
    mem_req_ready = 1'b0;
    #1;
    chk("wd_stall", stall, 0);
    chk("wd_reqv", mem_req_valid, 0);
    tick;
    old = rd_mem(w);
    for (int b = 0; b < 4; b++) if (mask[b]) old[8*b +: 8] = din[8*b +: 8];
    mem[w] = old;
    if (mv[idx] && mt[idx] == a[31:8]) md[idx] = old;
    cpu_we = 4'b0;
    cpu_re = 1'b0;
    chk("st_nreq", nreq - n0, 1);
    chk_counts();
  endtask

  task automatic do_idle;
    cpu_re = 1'b0;
    cpu_we = 4'b0;
    #1;
    chk("idle_stall", stall, 0);
    chk("idle_dout", cpu_dout, 0);
    chk("idle_reqv", mem_req_valid, 0);
    tick;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int op;
    reset = 1'b1;
    cpu_addr = 32'h100;
    cpu_re = 1'b1;
    cpu_we = 4'b0;
    cpu_din = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    model_reset();
    tick;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_reqv", mem_req_valid, 0);
    chk("rst_dout", cpu_dout, 0);
    tick;
    reset = 1'b0;
    cpu_re = 1'b0;
    #1;
    chk_counts();
    do_idle();

    mem[30'h40] = 32'hDEADBEEF;
    do_load(32'h100, 0, 3, got);
    chk("tp_first", got, 32'hDEADBEEF);
    chk("tp_hits1", hit_count, 1);
    chk("tp_miss1", miss_count, 1);
    do_load(32'h100, 1, 0, got);
    chk("tp_rehit", got, 32'hDEADBEEF);
    chk("tp_hits2", hit_count, 2);
    do_store(32'h100, 4'b0011, 32'h00001234, 2);
    do_load(32'h100, 0, 0, got);
    chk("tp_merge", got, 32'hDEAD1234);
    do_store(32'h200, 4'b1111, 32'hCAFEF00D, 0);
    do_load(32'h200, 0, 1, got);
    chk("tp_noalloc_miss", miss_count, 2);
    chk("tp_wt_data", got, 32'hCAFEF00D);
    do_load(32'h1100, 1, 2, got);
    chk("tp_alias_miss", miss_count, 3);
    do_load(32'h100, 0, 0, got);
    chk("tp_evict_miss", miss_count, 4);
    chk("tp_evict_data", got, 32'hDEAD1234);

    cpu_addr = 32'h300;
    cpu_re = 1'b1;
    tick;
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    chk("rw_rst_stall", stall, 0);
    chk("rw_rst_reqv", mem_req_valid, 0);
    chk("rw_rst_dout", cpu_dout, 0);
    tick;
    reset = 1'b0;
    cpu_re = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0BADF00D;
    #1;
    chk("late_resp_stall", stall, 0);
    tick;
    mem_resp_valid = 1'b0;
    model_reset();
    do_load(32'h100, 0, 0, got);
    chk("post_rst_miss", miss_count, 1);
    do_load(32'h300, 0, 0, got);
    chk("late_resp_ign", miss_count, 2);

    for (int n = 0; n < 200; n++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if (op < 5) do_load(a, $urandom_range(0, 3), $urandom_range(0, 3), got);
      else if (op < 8) do_store(a, 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3));
      else do_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
